// File: rtl/multicycle_control.sv
// multicycle_control
//   Sequenced control unit for the 141L processor. Each instruction walks
//   FETCH -> DECODE -> (EXEC) -> (MEM) -> (WB) and every datapath strobe is
//   qualified by the current phase. The instruction fields are captured once
//   in DECODE, so the instruction register may change afterwards without
//   disturbing the strobes of the instruction in flight.
//
// Parameters
//   OPW         opcode width; bits above [3:0] must be zero for a legal opcode
//   MEM_TIMEOUT maximum MEM wait cycles before faulting (0 = wait forever)
//   CNTW        width of the performance counters
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 holds IDLE/FETCH; ignored in every other phase
//   format, opcode, sign  instruction fields from the instruction register
//   mem_ready             data-memory completion while in MEM
//   irWrite, pcInc        FETCH strobes
//   regWrite, writeSrc    WB register write and its source (ALU=11 MEM=00 IMM=01)
//   memRead, memWrite     MEM strobes, held until mem_ready
//   cpin, cpout           cp direction strobes in WB
//   branch, jump          one-cycle EXEC strobes
//   halt, fault           held in HALTED; fault only after a MEM timeout
//   state                 IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALTED=6
//   instr_count,
//   cycle_count           performance counters
//
// Build option
//   CTRL_PERFCNT_EN  when defined, instr_count/cycle_count are live counters;
//                    otherwise both are tied to zero and no counter flops exist.

module multicycle_control #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            format,
  input  logic [OPW-1:0]  opcode,
  input  logic            sign,
  input  logic            mem_ready,
  output logic            irWrite,
  output logic            pcInc,
  output logic            regWrite,
  output logic [1:0]      writeSrc,
  output logic            memRead,
  output logic            memWrite,
  output logic            cpin,
  output logic            cpout,
  output logic            branch,
  output logic            jump,
  output logic            halt,
  output logic            fault,
  output logic [2:0]      state,
  output logic [CNTW-1:0] instr_count,
  output logic [CNTW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6
  } state_t;

  // Instruction classes; everything after DECODE is steered by class only.
  typedef enum logic [3:0] {
    C_IMM, C_ALU, C_DEF, C_LOAD, C_EPAR, C_STORE, C_CP, C_BRANCH, C_JUMP, C_HALT
  } class_t;

  localparam logic [1:0] WS_MEM = 2'b00;
  localparam logic [1:0] WS_IMM = 2'b01;
  localparam logic [1:0] WS_ALU = 2'b11;

  // Wait counter wide enough to hold MEM_TIMEOUT; one spare bit for the compare.
  localparam int          WW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW:0] TMO = (WW + 1)'(MEM_TIMEOUT);

  function automatic class_t classify(input logic f, input logic [OPW-1:0] op);
    class_t c;
    if (!f)
      c = C_IMM;
    else if ((op >> 4) != '0)
      c = C_DEF;                // nonzero upper bits are never a legal opcode
    else begin
      case (4'(op))
        4'b0000, 4'b1010: c = C_ALU;
        4'b0001:          c = C_LOAD;
        4'b0010:          c = C_STORE;
        4'b0011:          c = C_JUMP;
        4'b0100:          c = C_BRANCH;
        4'b0101:          c = C_EPAR;
        4'b0111:          c = C_CP;
        4'b1011:          c = C_HALT;
        default:          c = C_DEF;
      endcase
    end
    return c;
  endfunction

  state_t          r_state;
  state_t          w_next;
  logic            r_format;
  logic [OPW-1:0]  r_opcode;
  logic            r_sign;
  logic [WW-1:0]   r_wait;
  logic            r_fault;
  class_t          w_dec_class;   // live fields, used only to leave DECODE
  class_t          w_cls;         // latched fields, used by all later phases
  logic [WW:0]     w_wait_inc;
  logic            w_timeout;

  assign w_dec_class = classify(format, opcode);
  assign w_cls       = classify(r_format, r_opcode);
  assign w_wait_inc  = {1'b0, r_wait} + (WW + 1)'(1);
  // This MEM cycle is the MEM_TIMEOUT-th one without mem_ready.
  assign w_timeout   = (MEM_TIMEOUT != 0) && (w_wait_inc == TMO);
  assign state       = r_state;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create order races.
  // The latched fields are reset too, so outputs are defined straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_format <= 1'b0;
      r_opcode <= '0;
      r_sign   <= 1'b0;
      r_wait   <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_format <= format;
        r_opcode <= opcode;
        r_sign   <= sign;
      end
      if (w_next == S_MEM && r_state != S_MEM)
        r_wait <= '0;
      else if (r_state == S_MEM && !mem_ready)
        r_wait <= w_wait_inc[WW-1:0];
      if (r_state == S_MEM && !mem_ready && w_timeout)
        r_fault <= 1'b1;
    end
  end

  // NOTE: every output and w_next gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    w_next   = r_state;
    irWrite  = 1'b0;
    pcInc    = 1'b0;
    regWrite = 1'b0;
    writeSrc = WS_MEM;
    memRead  = 1'b0;
    memWrite = 1'b0;
    cpin     = 1'b0;
    cpout    = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    halt     = 1'b0;
    fault    = 1'b0;

    case (r_state)
      S_IDLE: if (!stall) w_next = S_FETCH;

      S_FETCH: begin
        if (!stall) begin
          irWrite = 1'b1;
          pcInc   = 1'b1;
          w_next  = S_DECODE;
        end
      end

      S_DECODE: begin
        case (w_dec_class)
          C_IMM, C_CP: w_next = S_WB;
          C_HALT:      w_next = S_HALTED;
          default:     w_next = S_EXEC;
        endcase
      end

      S_EXEC: begin
        case (w_cls)
          C_LOAD, C_EPAR, C_STORE: w_next = S_MEM;
          C_BRANCH: begin branch = 1'b1; w_next = S_FETCH; end
          C_JUMP:   begin jump   = 1'b1; w_next = S_FETCH; end
          default:  w_next = S_WB;
        endcase
      end

      S_MEM: begin
        memWrite = (w_cls == C_STORE);
        memRead  = (w_cls != C_STORE);
        // mem_ready is tested first so a completion on the timeout edge wins.
        if (mem_ready)
          w_next = (w_cls == C_STORE) ? S_FETCH : S_WB;
        else if (w_timeout)
          w_next = S_HALTED;
      end

      S_WB: begin
        w_next = S_FETCH;
        case (w_cls)
          C_CP: begin
            cpout = r_sign;
            cpin  = !r_sign;
          end
          C_LOAD:        begin regWrite = 1'b1; writeSrc = WS_MEM; end
          C_ALU, C_EPAR: begin regWrite = 1'b1; writeSrc = WS_ALU; end
          default:       begin regWrite = 1'b1; writeSrc = WS_IMM; end
        endcase
      end

      S_HALTED: begin
        halt  = 1'b1;
        fault = r_fault;
      end

      default: w_next = S_IDLE;
    endcase
  end

`ifdef CTRL_PERFCNT_EN
  logic [CNTW-1:0] r_cycle_count;
  logic [CNTW-1:0] r_instr_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALTED)
        r_cycle_count <= r_cycle_count + CNTW'(1);
      // Retirement: return to FETCH from any terminal phase of an instruction.
      if (w_next == S_FETCH &&
          (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB))
        r_instr_count <= r_instr_count + CNTW'(1);
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed bench for multicycle_control. Each instruction is expanded into
//   its expected per-cycle phase trace from the instruction-class rules; one
//   compare process checks the DUT against that trace every cycle, and the
//   performance counters against cycle/retirement counts kept from the trace.

`timescale 1ns/1ps

module tb_multicycle_control;

  localparam int OPW  = 6;
  localparam int TMO  = 4;
  localparam int CNTW = 4;

`ifdef CTRL_PERFCNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall;
  logic            format;
  logic [OPW-1:0]  opcode;
  logic            sign;
  logic            mem_ready;
  logic            irWrite, pcInc, regWrite;
  logic [1:0]      writeSrc;
  logic            memRead, memWrite, cpin, cpout, branch, jump, halt, fault;
  logic [2:0]      state;
  logic [CNTW-1:0] instr_count, cycle_count;

  always #5 clk = ~clk;

  multicycle_control #(.OPW(OPW), .MEM_TIMEOUT(TMO), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .format(format), .opcode(opcode),
    .sign(sign), .mem_ready(mem_ready), .irWrite(irWrite), .pcInc(pcInc),
    .regWrite(regWrite), .writeSrc(writeSrc), .memRead(memRead),
    .memWrite(memWrite), .cpin(cpin), .cpout(cpout), .branch(branch),
    .jump(jump), .halt(halt), .fault(fault), .state(state),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  typedef struct packed {
    logic [2:0] st;
    logic ir, pc, rw;
    logic [1:0] ws;
    logic mr, mw, ci, co, br, jp, ht, ft;
  } exp_t;

  typedef enum int {
    K_IMM, K_ALU, K_DEF, K_LOAD, K_EPAR, K_STORE, K_CP, K_BR, K_JMP, K_HALT
  } kind_t;

  exp_t act;
  assign act = {state, irWrite, pcInc, regWrite, writeSrc, memRead, memWrite,
                cpin, cpout, branch, jump, halt, fault};

  int         total = 0;
  int         bad   = 0;
  exp_t       q[$];
  exp_t       e_cur;
  int         m_cyc = 0;
  int         m_ins = 0;
  logic [2:0] prev_st = 3'd0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic kind_t kind(input logic f, input logic [OPW-1:0] op);
    if (!f)     return K_IMM;
    if (op > 15) return K_DEF;
    case (op)
      0, 10:   return K_ALU;
      1:       return K_LOAD;
      2:       return K_STORE;
      3:       return K_JMP;
      4:       return K_BR;
      5:       return K_EPAR;
      7:       return K_CP;
      11:      return K_HALT;
      default: return K_DEF;
    endcase
  endfunction

  // Compare process: one expected trace entry per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e_cur = q.pop_front();
      if (prev_st != 3'd0 && prev_st != 3'd6) m_cyc++;
      if ((prev_st == 3'd3 || prev_st == 3'd4 || prev_st == 3'd5) && e_cur.st == 3'd1) m_ins++;
      check("outs", 32'(act), 32'(e_cur));
      check("cycle_count", 32'(cycle_count), PERF ? 32'(m_cyc % (1 << CNTW)) : 32'd0);
      check("instr_count", 32'(instr_count), PERF ? 32'(m_ins % (1 << CNTW)) : 32'd0);
      prev_st = e_cur.st;
    end
  end

  // Called at posedge+1: drive inputs for this cycle, queue its expectation.
  task automatic step(input exp_t e, input logic s_stall, input logic f,
                      input logic [OPW-1:0] op, input logic sg, input logic rdy);
    stall     = s_stall;
    format    = f;
    opcode    = op;
    sign      = sg;
    mem_ready = rdy;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Phases that ignore stall and the instruction fields get random values there.
  task automatic gstep(input exp_t e, input logic rdy);
    step(e, 1'($urandom), 1'($urandom), OPW'($urandom), 1'($urandom), rdy);
  endtask

  // One instruction starting in FETCH. n counts cycles from the fetch strobe
  // to the next FETCH (or to HALTED entry); hold = cycles spent in HALTED.
  task automatic instr(input logic f, input logic [OPW-1:0] op, input logic sg,
                       input int fst, input int w, input int hold, output int n);
    exp_t  e;
    kind_t k;
    int    mem_n;
    bit    to;
    k = kind(f, op);
    n = 0;
    for (int i = 0; i < fst; i++)
      step(mk(3'd1), 1'b1, 1'($urandom), OPW'($urandom), 1'($urandom), 1'b0);
    e = mk(3'd1); e.ir = 1'b1; e.pc = 1'b1;
    step(e, 1'b0, ~f, ~op, ~sg, 1'b0); n++;
    step(mk(3'd2), 1'($urandom), f, op, sg, 1'b0); n++;
    case (k)
      K_IMM: begin
        e = mk(3'd5); e.rw = 1'b1; e.ws = 2'b01; gstep(e, 1'($urandom)); n++;
      end
      K_CP: begin
        e = mk(3'd5); e.co = sg; e.ci = !sg; gstep(e, 1'($urandom)); n++;
      end
      K_BR: begin
        e = mk(3'd3); e.br = 1'b1; gstep(e, 1'($urandom)); n++;
      end
      K_JMP: begin
        e = mk(3'd3); e.jp = 1'b1; gstep(e, 1'($urandom)); n++;
      end
      K_HALT: begin
        e = mk(3'd6); e.ht = 1'b1;
        for (int i = 0; i < hold; i++) gstep(e, 1'($urandom));
      end
      K_ALU, K_DEF: begin
        gstep(mk(3'd3), 1'($urandom)); n++;
        e = mk(3'd5); e.rw = 1'b1; e.ws = (k == K_ALU) ? 2'b11 : 2'b01;
        gstep(e, 1'($urandom)); n++;
      end
      default: begin  // load, epar, store
        gstep(mk(3'd3), 1'($urandom)); n++;
        to    = (w >= TMO);
        mem_n = to ? TMO : w + 1;
        for (int j = 0; j < mem_n; j++) begin
          e = mk(3'd4); e.mr = (k != K_STORE); e.mw = (k == K_STORE);
          gstep(e, !to && j == w); n++;
        end
        if (to) begin
          e = mk(3'd6); e.ht = 1'b1; e.ft = 1'b1;
          for (int i = 0; i < hold; i++) gstep(e, 1'b1);
        end else if (k != K_STORE) begin
          e = mk(3'd5); e.rw = 1'b1; e.ws = (k == K_LOAD) ? 2'b00 : 2'b11;
          gstep(e, 1'($urandom)); n++;
        end
      end
    endcase
  endtask

  // Called at posedge+1; outputs must drop before the next clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_outs", 32'(act), 32'(mk(3'd0)));
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_instr_count", 32'(instr_count), 32'd0);
    q.delete();
    m_cyc   = 0;
    m_ins   = 0;
    prev_st = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    stall     = 1'b1;
    format    = 1'b0;
    opcode    = '0;
    sign      = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    step(mk(3'd0), 1'b1, 1'b1, 6'h01, 1'b0, 1'b1);   // IDLE held by stall
    step(mk(3'd0), 1'b0, 1'b1, 6'h01, 1'b0, 1'b1);   // IDLE -> FETCH

    instr(1'b0, 6'h0B, 1'b0, 0, 0, 0, n); check("lat_imm", n, 3);
    instr(1'b1, 6'h00, 1'b0, 0, 0, 0, n); check("lat_add", n, 4);
    instr(1'b1, 6'h0A, 1'b0, 2, 0, 0, n); check("lat_shift", n, 4);
    instr(1'b1, 6'h01, 1'b0, 0, 3, 0, n); check("lat_load_w3", n, 8);
    instr(1'b1, 6'h05, 1'b0, 0, 0, 0, n); check("lat_epar_w0", n, 5);
    instr(1'b1, 6'h05, 1'b1, 0, 2, 0, n); check("lat_epar_w2", n, 7);
    instr(1'b1, 6'h02, 1'b0, 0, 1, 0, n); check("lat_store_w1", n, 5);
    instr(1'b1, 6'h04, 1'b0, 0, 0, 0, n); check("lat_branch", n, 3);
    instr(1'b1, 6'h03, 1'b0, 1, 0, 0, n); check("lat_jump", n, 3);
    instr(1'b1, 6'h07, 1'b1, 0, 0, 0, n); check("lat_cpout", n, 3);
    instr(1'b1, 6'h07, 1'b0, 0, 0, 0, n); check("lat_cpin", n, 3);
    instr(1'b1, 6'h10, 1'b0, 0, 0, 0, n); check("lat_default_hi", n, 4);
    instr(1'b1, 6'h06, 1'b0, 0, 0, 0, n); check("lat_default_06", n, 4);
    instr(1'b1, 6'h0F, 1'b0, 0, 0, 0, n); check("lat_default_0f", n, 4);
    instr(1'b1, 6'h02, 1'b0, 0, 100, 3, n); check("lat_store_tmo", n, 3 + TMO);
    check("tmo_halt", 32'(halt), 32'd1);
    check("tmo_fault", 32'(fault), 32'd1);
    check("tmo_state", 32'(state), 32'd6);
    do_reset();

    step(mk(3'd0), 1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    instr(1'b1, 6'h0B, 1'b0, 0, 0, 3, n); check("lat_halt", n, 2);
    check("halt_held", 32'(halt), 32'd1);
    check("halt_no_fault", 32'(fault), 32'd0);
    do_reset();
    step(mk(3'd0), 1'b1, 1'b1, 6'h02, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequenced successor to the single-cycle control decoder of the 141L processor. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB phases, latches the decoded fields once per instruction, and qualifies every datapath strobe by phase. A data-memory ready handshake is supported, with an optional timeout-to-fault. It sits between the instruction register and the datapath, replacing the purely combinational decoder.

## Interface
- OPW, 4: opcode width; bits above [3:0] must be zero for a legal opcode.
- MEM_TIMEOUT, 15: maximum cycles spent waiting in MEM; 0 disables the timeout.
- CNTW, 16: width of the performance counters.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  holds the block in IDLE/FETCH without fetching.
- format  in  1  0 = res/immediate format, 1 = opcode format.
- opcode  in  OPW  opcode field from the instruction register.
- sign  in  1  cp direction; 1 = cpout, 0 = cpin.
- mem_ready  in  1  data-memory completion for the current memRead or memWrite.
- irWrite, pcInc  out  1  instruction-register load and PC increment, both in FETCH.
- regWrite  out  1  register-file write in WB.
- writeSrc  out  2  ALU=11, MEM=00, IMM=01, RES=10; 00 whenever regWrite=0.
- memRead, memWrite, cpin, cpout, branch, jump, halt, fault  out  1  phase-qualified strobes and status.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6.
- instr_count, cycle_count  out  CNTW  performance counters.

## Operation
- Opcodes: add=0000, load=0001, store=0010, jump=0011, branch=0100, epar=0101, cp=0111, shift=1010, halt=1011. Any other value, including nonzero upper bits, is treated as "default".
- DECODE latches format, opcode and sign into internal registers. Later phases use only the latched copies.
- Outputs are combinational from state plus the latched fields. Every output is 0 in IDLE.
- IDLE → FETCH when stall=0.
- FETCH with stall=0: irWrite=pcInc=1, then → DECODE. FETCH with stall=1: hold, strobes 0.
- Paths from DECODE, by instruction class:
  - format 0: → WB, with regWrite=1 and writeSrc=IMM.
  - add, shift, default: → EXEC → WB. WB drives writeSrc=ALU for add/shift and IMM for default.
  - load: → EXEC → MEM (memRead=1) → WB with writeSrc=MEM.
  - epar: → EXEC → MEM (memRead=1) → WB with writeSrc=ALU.
  - store: → EXEC → MEM (memWrite=1) → FETCH. No regWrite.
  - cp: → WB. cpout=1 if sign=1, else cpin=1. regWrite=0.
  - branch / jump: → EXEC, where branch=1 or jump=1 for one cycle, then → FETCH.
  - halt: → HALTED.
- WB → FETCH always.
- MEM behaviour:
  - memRead or memWrite stays asserted while in MEM.
  - Exit on the rising edge where mem_ready=1; mem_ready=1 on the first MEM cycle gives a single-cycle MEM.
  - A wait counter clears on MEM entry and increments each MEM cycle with mem_ready=0.
  - If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT with mem_ready still 0: → HALTED with fault=1.
  - mem_ready on the same edge as the timeout wins: MEM completes normally and there is no fault.
- HALTED: halt=1 (and fault=1 if the entry was by timeout). All other strobes are 0. Only rst_n exits.
- stall is ignored outside IDLE and FETCH.

## Timing
- Reset: state=IDLE, latched fields=0, wait counter=0, fault=0, counters=0, so every output is 0. Reset asserted mid-instruction aborts immediately; a strobe asserted at that moment drops asynchronously.
- Latency, FETCH to next FETCH: format0/cp 3 cycles; add/shift/default 4; branch/jump 3; store 4+w; load/epar 5+w, where w is the number of mem_ready=0 MEM cycles.
- Every strobe lasts exactly one cycle, except MEM strobes (1+w cycles) and halt/fault (held).

## Configuration
- CTRL_PERFCNT_EN defined:
  - cycle_count increments every cycle state∉{IDLE,HALTED}.
  - instr_count increments on every transition into FETCH from WB, EXEC or MEM.
  - Both wrap modulo 2^CNTW.
- CTRL_PERFCNT_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Test plan
- Reset released with stall=0, then format=0: state sequence 0,1,2,5,1; regWrite=1 with writeSrc=01 only in WB.
- load with mem_ready low 3 cycles: memRead high for 4 MEM cycles, WB writeSrc=00; instr_count +1 (PERFCNT on).
- store with MEM_TIMEOUT=2 and mem_ready stuck 0: state reaches 6 after 2 MEM cycles with fault=1 and halt=1; mem_ready rising afterwards causes no change.
- cp with sign=1 then sign=0: cpout pulse, then cpin pulse, each 1 cycle in WB, regWrite=0. Changing opcode after DECODE does not alter the strobes.
- opcode=1011: halt=1 from the cycle after DECODE; rst_n pulse low returns all outputs to 0 and state to 0.
- OPW=6, opcode=010000: treated as default, 4-cycle path, WB writeSrc=01; with CTRL_PERFCNT_EN and CNTW=4, cycle_count wraps 15→0.
